register_file_sb: RTL
=====================

Name: register_file_sb

Overview:
- Parametrised successor to the single-write, dual-read register_file.
- Adds a configurable number of read ports and optional write-to-read bypass.
- Adds a hardwired-zero register, synchronous reset of register contents, and a pending-write scoreboard (busy bits) for pipelined hazard detection.
- Sits between decode (issue/read) and writeback in the pipelined core.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers (power of two, ≥2).
- AW, $clog2(NREGS), register address width (derived; do not override).
- NRD, 2, number of read ports (1..4).
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports; 0 = reads see only stored contents.
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes and issues.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- reg_write  in  1  write enable.
- rd  in  AW  write address.
- write_data  in  XLEN  write data.
- rs  in  NRD*AW  read addresses; port i occupies bits [i*AW +: AW].
- read_data  out  NRD*XLEN  read data; port i occupies bits [i*XLEN +: XLEN].
- issue_valid  in  1  an instruction with destination issue_rd is issued this cycle.
- issue_rd  in  AW  destination of the issued instruction.
- rs_busy  out  NRD  bit i = 1 when register rs[i] has a pending write.
- busy_count  out  AW+1  number of registers currently marked busy.

Behaviour:
- Reset: `rst` is sampled on `clk`. Asserting it for one edge sets all registers to 0, all busy bits to 0 and busy_count to 0. While `rst` is high, reg_write and issue_valid are ignored. Out of reset, read_data reads 0 and rs_busy reads 0 for all ports.
- Write: if reg_write = 1 at the edge, mem[rd] <= write_data. Excluded when ZERO_REG = 1 and rd = 0.
- Read: combinational with zero latency.
  - read_data[i] = 0 when ZERO_REG = 1 and rs[i] = 0.
  - Otherwise, when BYPASS = 1, reg_write = 1 and rd = rs[i], read_data[i] = write_data.
  - Otherwise read_data[i] = mem[rs[i]].
- Scoreboard, per register r at each edge:
  - Set: issue_valid = 1 and issue_rd = r.
  - Clear: reg_write = 1 and rd = r.
  - Set and clear together: busy stays 1. The writeback belongs to the older producer; the new issue is still pending.
  - Clear without a prior set: no effect, busy stays 0.
  - Set when already busy: stays 1. There is no counting per register; the team guarantees a single outstanding producer.
  - ZERO_REG = 1: register 0 is never busy.
- rs_busy[i]: combinational, equals busy[rs[i]]. No bypass of the current cycle's set or clear; it reflects registered state.
- busy_count: registered population count of the busy bits, updated on the same edge as the busy bits. Range 0..NREGS (0..NREGS-1 when ZERO_REG = 1). It never wraps because AW+1 bits hold NREGS.
- Reset mid-operation wins over any same-cycle write or issue.
- Read-port address collisions (several ports reading the same register) are legal and return identical data.

Decomposition:
- No shared package is needed. Parameters are local; the zero-register index 0 is a localparam.
- One natural sub-module, `regfile_scoreboard`: busy vector, set/clear priority and busy_count, with parameters NREGS and ZERO_REG.
- Storage and read muxing stay in the top module, generated over NRD.

Test Plan:
- Reset then read: assert rst for 1 cycle, set rs = {5'd1, 5'd31} → read_data = {0, 0}, rs_busy = 0, busy_count = 0.
- Write then read: write DEADBEEF to x1, next cycle write 12345678 to x2, then read rs0 = 1, rs1 = 2 → DEADBEEF and 12345678.
- Bypass: in the same cycle, reg_write with rd = 3, write_data = A5A5A5A5 and rs0 = 3 → read_data0 = A5A5A5A5 (BYPASS = 1). Rerun with BYPASS = 0 → read_data0 shows the old value (0), then A5A5A5A5 the next cycle.
- x0: write FFFFFFFF to rd = 0 and issue_rd = 0 → reading x0 returns 0, rs_busy stays 0, busy_count stays 0.
- Scoreboard: issue x5, then rs0 = 5 → rs_busy0 = 1, busy_count = 1. Writeback x5 together with a new issue of x5 → busy stays 1, count stays 1. Writeback x5 alone → busy 0, count 0.
- Reset mid-operation: issue x4 and x6 and write x7 = 1111, then assert rst in the same cycle as a write of x8 = 2222 → all reads return 0, busy_count = 0, x8 is not written.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue, cleared on writeback,
// with a registered population count of the busy bits.
module regfile_scoreboard #(
    parameter int unsigned NREGS    = 32,
    parameter int unsigned AW       = $clog2(NREGS),
    parameter int unsigned ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_rd,
    input  logic             wb_valid,
    input  logic [AW-1:0]    wb_rd,
    output logic [NREGS-1:0] busy,
    output logic [AW:0]      busy_count
);

    localparam int unsigned CW = AW + 1;

    logic [NREGS-1:0] busy_d, busy_q;
    logic [CW-1:0]    count_d, count_q;

    // A same-edge set wins over clear: the writeback retires the older producer.
    always_comb begin
        busy_d  = busy_q;
        count_d = '0;
        for (int unsigned r = 0; r < NREGS; r++) begin
            if (issue_valid && (issue_rd == AW'(r))) begin
                busy_d[r] = 1'b1;
            end else if (wb_valid && (wb_rd == AW'(r))) begin
                busy_d[r] = 1'b0;
            end
        end
        if (ZERO_REG != 0) begin
            busy_d[0] = 1'b0;
        end
        for (int unsigned r = 0; r < NREGS; r++) begin
            count_d = count_d + CW'(busy_d[r]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign busy       = busy_q;
    assign busy_count = count_q;

endmodule

// File: rtl/register_file_sb.sv
// Parametrised register file with NRD combinational read ports, optional write-to-read
// bypass, hardwired-zero register and a pending-write scoreboard for hazard detection.
module register_file_sb #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned AW       = $clog2(NREGS),
    parameter int unsigned NRD      = 2,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                reg_write,
    input  logic [AW-1:0]       rd,
    input  logic [XLEN-1:0]     write_data,
    input  logic [NRD*AW-1:0]   rs,
    output logic [NRD*XLEN-1:0] read_data,
    input  logic                issue_valid,
    input  logic [AW-1:0]       issue_rd,
    output logic [NRD-1:0]      rs_busy,
    output logic [AW:0]         busy_count
);

    localparam logic [AW-1:0] ZERO_IDX = '0;

    logic [XLEN-1:0]  mem_d [NREGS];
    logic [XLEN-1:0]  mem_q [NREGS];
    logic [NREGS-1:0] busy;
    logic             write_en;

    assign write_en = reg_write && !((ZERO_REG != 0) && (rd == ZERO_IDX));

    always_comb begin
        mem_d = mem_q;
        if (write_en) begin
            mem_d[rd] = write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    regfile_scoreboard #(
        .NREGS    (NREGS),
        .AW       (AW),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .wb_valid    (reg_write),
        .wb_rd       (rd),
        .busy        (busy),
        .busy_count  (busy_count)
    );

    // Per-port read mux; busy lookup uses registered state only.
    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] port_data;

        assign addr = rs[i*AW +: AW];

        always_comb begin
            port_data = mem_q[addr];
            if ((ZERO_REG != 0) && (addr == ZERO_IDX)) begin
                port_data = '0;
            end else if ((BYPASS != 0) && reg_write && (rd == addr)) begin
                port_data = write_data;
            end
        end

        assign read_data[i*XLEN +: XLEN] = port_data;
        assign rs_busy[i]                = busy[addr];
    end

endmodule
